// File: rtl/coin_validator_if.sv
// Coin-chute bus between the chute/collector side and the validator.
// Carries sensor + accept_en in, coin code, reject gate, fault and audit counts out.
interface coin_validator_if;
    logic       coin_sense;
    logic       accept_en;
    logic [1:0] coin_code;
    logic       reject_out;
    logic       fault;
    logic [7:0] nickel_cnt;
    logic [7:0] dime_cnt;
    logic [7:0] reject_cnt;

    modport master (
        output coin_sense, accept_en,
        input  coin_code, reject_out, fault,
        input  nickel_cnt, dime_cnt, reject_cnt
    );

    modport slave (
        input  coin_sense, accept_en,
        output coin_code, reject_out, fault,
        output nickel_cnt, dime_cnt, reject_cnt
    );
endinterface

// File: rtl/coin_validator.sv
// Coin validator: syncs the chute sensor, measures and merges pulses, classifies nickel/dime.
// Ports: clk, sync_reset_n (sync, active-low), bus (slave: sensor/accept in, code/reject/fault/counts out).
module coin_validator #(
    parameter int unsigned NICKEL_MIN = 4,
    parameter int unsigned NICKEL_MAX = 8,
    parameter int unsigned DIME_MIN   = 12,
    parameter int unsigned DIME_MAX   = 20,
    parameter int unsigned GAP        = 4,
    parameter int unsigned STUCK_LIM  = 200
) (
    input  logic             clk,
    input  logic             sync_reset_n,
    coin_validator_if.slave  bus
);

    localparam logic [7:0] N_MIN  = 8'(NICKEL_MIN);
    localparam logic [7:0] N_MAX  = 8'(NICKEL_MAX);
    localparam logic [7:0] D_MIN  = 8'(DIME_MIN);
    localparam logic [7:0] D_MAX  = 8'(DIME_MAX);
    localparam logic [7:0] GAP_M1 = 8'(GAP - 1);
    localparam logic [7:0] STUCK  = 8'(STUCK_LIM);

    typedef enum logic [2:0] {
        ARM, IDLE, HIGH, LOW_WAIT, EMIT, ST_STUCK
    } state_t;

    state_t     state_q, state_d;
    logic       s1_q, s_q;
    logic [7:0] w_q, w_d;
    logic [7:0] g_q, g_d;
    logic [1:0] code_q, code_d;
    logic       rej_q, rej_d;
    logic       fault_q, fault_d;
    logic [7:0] ncnt_q, ncnt_d;
    logic [7:0] dcnt_q, dcnt_d;
    logic [7:0] rcnt_q, rcnt_d;

    logic [7:0] w_inc;
    logic       is_nickel;
    logic       is_dime;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign w_inc     = sat_inc(w_q);
    assign is_nickel = (w_q >= N_MIN) && (w_q <= N_MAX);
    assign is_dime   = (w_q >= D_MIN) && (w_q <= D_MAX);

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state_q <= ARM;
            s1_q    <= 1'b0;
            s_q     <= 1'b0;
            w_q     <= 8'd0;
            g_q     <= 8'd0;
            code_q  <= 2'b00;
            rej_q   <= 1'b0;
            fault_q <= 1'b0;
            ncnt_q  <= 8'd0;
            dcnt_q  <= 8'd0;
            rcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            s1_q    <= bus.coin_sense;
            s_q     <= s1_q;
            w_q     <= w_d;
            g_q     <= g_d;
            code_q  <= code_d;
            rej_q   <= rej_d;
            fault_q <= fault_d;
            ncnt_q  <= ncnt_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        g_d     = g_q;
        code_d  = 2'b00;
        rej_d   = 1'b0;
        fault_d = fault_q;
        ncnt_d  = ncnt_q;
        dcnt_d  = dcnt_q;
        rcnt_d  = rcnt_q;

        unique case (state_q)
            ARM: begin
                // The synchronizer restarts from 0 after reset, so its
                // output only reflects the sensor after two clocks; g
                // counts those fill cycles before s is trusted.
                if (g_q != 8'd2) begin
                    g_d = g_q + 8'd1;
                end else if (!s_q) begin
                    state_d = IDLE;
                    g_d     = 8'd0;
                end
            end
            IDLE: begin
                if (s_q) begin
                    state_d = HIGH;
                    w_d     = 8'd1;
                end
            end
            HIGH, LOW_WAIT: begin
                if (s_q) begin
                    w_d     = w_inc;
                    state_d = HIGH;
                    if (w_inc >= STUCK) begin
                        state_d = ST_STUCK;
                        fault_d = 1'b1;
                        g_d     = 8'd0;
                    end
                end else if (state_q == HIGH) begin
                    state_d = LOW_WAIT;
                    g_d     = 8'd1;
                end else if (g_q == GAP_M1) begin
                    state_d = EMIT;
                    g_d     = 8'd0;
                    if (is_nickel && bus.accept_en) begin
                        code_d = 2'b01;
                        ncnt_d = sat_inc(ncnt_q);
                    end else if (is_dime && bus.accept_en) begin
                        code_d = 2'b10;
                        dcnt_d = sat_inc(dcnt_q);
                    end else begin
                        rej_d  = 1'b1;
                        rcnt_d = sat_inc(rcnt_q);
                    end
                end else begin
                    g_d = g_q + 8'd1;
                end
            end
            EMIT: begin
                if (s_q) begin
                    state_d = HIGH;
                    w_d     = 8'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            ST_STUCK: begin
                if (s_q) begin
                    g_d = 8'd0;
                end else if (g_q == GAP_M1) begin
                    state_d = IDLE;
                    g_d     = 8'd0;
                end else begin
                    g_d = g_q + 8'd1;
                end
            end
            default: begin
                state_d = ARM;
                g_d     = 8'd0;
            end
        endcase
    end

    assign bus.coin_code  = code_q;
    assign bus.reject_out = rej_q;
    assign bus.fault      = fault_q;
    assign bus.nickel_cnt = ncnt_q;
    assign bus.dime_cnt   = dcnt_q;
    assign bus.reject_cnt = rcnt_q;

endmodule

// File: tb/tb_coin_validator.sv
// Directed bench for coin_validator: latency, classification, merge, stuck, reset, saturation.
// Drives the chute on falling edges and samples outputs on falling edges.
module tb_coin_validator;

    logic clk;
    logic sync_reset_n;
    int   passed;
    int   total;
    int   c01, c10, c11, crj;

    coin_validator_if bus ();

    coin_validator #(
        .NICKEL_MIN(4), .NICKEL_MAX(8),
        .DIME_MIN(12), .DIME_MAX(20),
        .GAP(4), .STUCK_LIM(200)
    ) dut (
        .clk         (clk),
        .sync_reset_n(sync_reset_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters of output cycles, used to check pulse counts.
    always @(negedge clk) begin
        if (bus.coin_code == 2'b01) c01++;
        if (bus.coin_code == 2'b10) c10++;
        if (bus.coin_code == 2'b11) c11++;
        if (bus.reject_out)         crj++;
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    endtask

    task automatic drive(input logic lvl, input int n);
        bus.coin_sense = lvl;
        repeat (n) @(negedge clk);
    endtask

    // Drop the sensor low and watch 10 cycles for the emitted result.
    task automatic watch(input string tag, input int exp_hits,
                         input int exp_code, input int exp_rej);
        int hits, at, code_s, rej_s;
        hits = 0; at = 0; code_s = 0; rej_s = 0;
        bus.coin_sense = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.coin_code != 2'b00 || bus.reject_out) begin
                hits++;
                at     = i;
                code_s = int'(bus.coin_code);
                rej_s  = int'(bus.reject_out);
            end
        end
        chk({tag, "_hits"}, hits, exp_hits);
        if (exp_hits == 1) begin
            chk({tag, "_lat"}, at, 6);
            chk({tag, "_code"}, code_s, exp_code);
            chk({tag, "_rej"}, rej_s, exp_rej);
        end
    endtask

    task automatic chk_cnt(input string tag, input int n, input int d, input int r);
        chk({tag, "_ncnt"}, int'(bus.nickel_cnt), n);
        chk({tag, "_dcnt"}, int'(bus.dime_cnt), d);
        chk({tag, "_rcnt"}, int'(bus.reject_cnt), r);
    endtask

    initial begin
        int b01, brj;
        passed = 0; total = 0;
        c01 = 0; c10 = 0; c11 = 0; crj = 0;
        bus.coin_sense = 1'b0;
        bus.accept_en  = 1'b1;
        sync_reset_n   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_code", int'(bus.coin_code), 0);
        chk("rst_rej", int'(bus.reject_out), 0);
        chk("rst_fault", int'(bus.fault), 0);
        chk_cnt("rst", 0, 0, 0);
        sync_reset_n = 1'b1;
        drive(1'b0, 6);

        drive(1'b1, 6);
        watch("nickel", 1, 1, 0);
        chk_cnt("nickel", 1, 0, 0);

        drive(1'b1, 15);
        watch("dime", 1, 2, 0);
        chk_cnt("dime", 1, 1, 0);

        drive(1'b1, 10);
        watch("between", 1, 0, 1);
        chk_cnt("between", 1, 1, 1);

        drive(1'b1, 3);
        watch("short", 1, 0, 1);
        chk_cnt("short", 1, 1, 2);

        drive(1'b1, 3);
        drive(1'b0, 2);
        drive(1'b1, 3);
        watch("merge", 1, 1, 0);
        chk_cnt("merge", 2, 1, 2);

        b01 = c01; brj = crj;
        drive(1'b1, 3);
        drive(1'b0, 4);
        drive(1'b1, 3);
        drive(1'b0, 12);
        chk("split_rej", crj - brj, 2);
        chk("split_01", c01 - b01, 0);
        chk_cnt("split", 2, 1, 4);

        bus.accept_en = 1'b0;
        drive(1'b1, 15);
        watch("busy", 1, 0, 1);
        chk_cnt("busy", 2, 1, 5);
        bus.accept_en = 1'b1;

        b01 = c01; brj = crj;
        drive(1'b1, 150);
        chk("stuck_pre", int'(bus.fault), 0);
        drive(1'b1, 100);
        chk("stuck_set", int'(bus.fault), 1);
        watch("stuck", 0, 0, 0);
        chk("stuck_01", c01 - b01, 0);
        chk("stuck_rj", crj - brj, 0);
        chk_cnt("stuck", 2, 1, 5);

        drive(1'b1, 6);
        watch("after_stuck", 1, 1, 0);
        chk("fault_hold", int'(bus.fault), 1);
        chk_cnt("after_stuck", 3, 1, 5);

        b01 = c01; brj = crj;
        drive(1'b1, 7);
        sync_reset_n = 1'b0;
        drive(1'b1, 3);
        chk("mid_rst_fault", int'(bus.fault), 0);
        chk_cnt("mid_rst", 0, 0, 0);
        sync_reset_n = 1'b1;
        drive(1'b1, 5);
        drive(1'b0, 12);
        chk("mid_rst_01", c01 - b01, 0);
        chk("mid_rst_rj", crj - brj, 0);
        chk("mid_rst_code", int'(bus.coin_code), 0);
        chk_cnt("post_rst", 0, 0, 0);

        drive(1'b1, 6);
        watch("rst_nickel", 1, 1, 0);
        chk_cnt("rst_nickel", 1, 0, 0);

        b01 = c01;
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, 6);
            drive(1'b0, 6);
        end
        drive(1'b0, 6);
        chk("sat_pulses", c01 - b01, 300);
        chk_cnt("sat", 255, 0, 0);
        chk("code11", c11, 0);
        chk("dime_pulses", c10, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/coin_validator.md
# coin_validator

Front-end stage of the vending machine that turns the raw coin-chute sensor into the per-cycle 2-bit coin code consumed by the coin collector. It synchronizes the sensor, measures the sensor-high pulse width, merges short dropouts, and classifies each pulse as a nickel or a dime. Every accepted coin produces exactly one single-cycle code. Rejected coins drive a return-gate pulse, and saturating audit counters record all accept and reject events.

## Interface
- NICKEL_MIN, 4, minimum width in cycles classified as a nickel
- NICKEL_MAX, 8, maximum width in cycles classified as a nickel
- DIME_MIN, 12, minimum width in cycles classified as a dime
- DIME_MAX, 20, maximum width in cycles classified as a dime
- GAP, 4, consecutive low samples that end a pulse; must be ≥2
- STUCK_LIM, 200, width at which the sensor is declared stuck; must be > DIME_MAX and < 256
- clk  input  1  single clock, rising edge
- sync_reset_n  input  1  reset, synchronous and active-low
- coin_sense  input  1  raw asynchronous chute sensor, high while a coin passes
- accept_en  input  1  high when the downstream collector is accepting coins
- coin_code  output  2  00 none, 01 nickel, 10 dime; 11 never driven
- reject_out  output  1  one-cycle return-gate pulse
- fault  output  1  sticky stuck-sensor flag
- nickel_cnt, dime_cnt, reject_cnt  output  8 each  saturating audit counters

## Operation
- Sampling: 2-flop synchronizer; `s` is the second flop. The FSM samples `s` once per clock.
- Width counter `w`: 8-bit and saturating. It counts only the high samples of `s` in the current pulse; low samples inside a merge gap are not counted.
- Gap counter `g`: counts consecutive low samples in LOW_WAIT.
- ARM (reset state): stay until `s`=0, then go to IDLE. A pulse already in progress at reset release is therefore ignored.
- IDLE: when `s`=1, go to HIGH with `w`=1.
- HIGH:
  - `s`=1: `w`++. When `w` reaches STUCK_LIM, go to STUCK and set `fault`=1.
  - `s`=0: go to LOW_WAIT with `g`=1.
- LOW_WAIT:
  - `s`=1: return to HIGH. This merges a glitch: `w` resumes from its held value and `w`++ for this sample.
  - `s`=0 with `g`=GAP−1: this is the GAP-th low sample. Classify the pulse, register the outputs, go to EMIT.
  - `s`=0 otherwise: `g`++.
- EMIT: lasts one cycle. Then go to IDLE, or to HIGH with `w`=1 if `s`=1.
- STUCK: no code is emitted. Wait for GAP consecutive low samples, then go to IDLE. `fault` stays 1 until reset.
- Classification is done at the registering edge, using `w`:
  - NICKEL_MIN ≤ `w` ≤ NICKEL_MAX: valid nickel.
  - DIME_MIN ≤ `w` ≤ DIME_MAX: valid dime.
  - Any other width: invalid.
- Actions, with accept_en sampled at the same registering edge:
  - Valid coin and accept_en=1: `coin_code` = 01 or 10; the matching count increments.
  - Valid coin and accept_en=0: `reject_out`=1, `coin_code`=00, `reject_cnt` increments.
  - Invalid coin: `reject_out`=1, `coin_code`=00, `reject_cnt` increments.
- Counters hold at 255 and never wrap.
- `coin_code` is 00 and `reject_out` is 0 in every cycle except the single EMIT cycle.

## Timing
- Reset: while `sync_reset_n`=0 at a rising edge, the next state is:
  - state = ARM; synchronizer flops, `w` and `g` = 0;
  - `coin_code` = 00, `reject_out` = 0, `fault` = 0;
  - all three counters = 0.
- Reset mid-pulse: the partial pulse is discarded, with no code and no count. Detection resumes after the first low sample of `s`.
- Latency:
  - The FSM sees a change on `coin_sense` 2 edges after the raw transition is first sampled.
  - Let edge n be the first edge that samples `coin_sense` low. `coin_code`/`reject_out` become valid after edge n+GAP+1 and clear after edge n+GAP+2.
  - With GAP=4, the output is valid during the cycle after edge n+5.
- Width: a clean raw high of W cycles gives `w`=W.
- Merge rule: a low dropout of GAP−1 or fewer samples is merged into the pulse. A low run of GAP samples ends the pulse.
- Minimum coin spacing: GAP+1 cycles of low between pulses. A new rise during EMIT is captured, not lost.
- The counters update on the same edge that registers `coin_code`.

## Test plan
- Nickel: accept_en=1, raw high for 6 cycles → `coin_code`=01 for exactly 1 cycle, 5 edges after the first low sample; `nickel_cnt`=1.
- Dime plus reject: raw high 15 → 10 with `dime_cnt`=1. Then raw high 10 (between bands) → `reject_out` 1-cycle pulse, `coin_code`=00, `reject_cnt`=1. Then raw high 3 → reject.
- Glitch merge: high 3, low 2, high 3 → a single 01 (`w`=6). High 3, low 4, high 3 → two rejects.
- Collector busy: accept_en=0 with a 15-cycle pulse → `reject_out` pulse, `coin_code` stays 00, `dime_cnt` unchanged.
- Stuck sensor: raw high 250 cycles, then low → `fault`=1 once `w` reaches 200; no code emitted; `fault` stays 1. A following 6-cycle pulse still yields 01.
- Reset: assert `sync_reset_n`=0 mid-way through a 15-cycle pulse, release while the sensor is still high → no code; all outputs and counters 0. The next 6-cycle pulse yields 01. Also check saturation: 300 nickels → `nickel_cnt`=255.
